// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU-side bus constants and types for the Game Boy OAM DMA block.
// Holds the DMA state encoding, register addresses and the echo-page fold helper.
package gb_cpu_common_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
   localparam logic [15:0] HIGH_PAGE_BASE = 16'hFF00;

   localparam logic [7:0] ECHO_PAGE_FIRST = 8'hE0;
   localparam logic [7:0] ECHO_PAGE_DELTA = 8'h20;

   // Pages E0-FF alias work RAM C0-DF on real hardware.
   function automatic logic [7:0] echo_fold(input logic [7:0] src);
      if (src >= ECHO_PAGE_FIRST) begin
         return src - ECHO_PAGE_DELTA;
      end
      return src;
   endfunction

endpackage

// File: rtl/gb_dma_bus_mux.sv
// Combinational routing of CPU, DMA, low bus, high page and OAM ports.
// The DMA owns the low bus only while xfer is high; the high page always belongs to the CPU.
module gb_dma_bus_mux
   import gb_cpu_common_pkg::*;
(
   input  logic        xfer,
   input  logic [7:0]  page,
   input  logic [7:0]  idx,
   input  logic [7:0]  src,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wren,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_wren,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  hi_addr,
   output logic [7:0]  hi_wdata,
   output logic        hi_wren,
   input  logic [7:0]  hi_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_wren
);

   logic is_high;
   logic is_dma_reg;

   assign is_high    = (cpu_addr >= HIGH_PAGE_BASE);
   assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);

   always_comb begin
      hi_addr   = cpu_addr[7:0];
      hi_wdata  = cpu_wdata;
      hi_wren   = cpu_wren & is_high;

      oam_addr  = idx;
      oam_wdata = mem_rdata;
      oam_wren  = xfer;

      if (xfer) begin
         mem_addr  = {page, idx};
         mem_wdata = 8'h00;
         mem_wren  = 1'b0;
      end else begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wren  = cpu_wren & ~is_high;
      end

      // The DMA register shadows whatever the high-page RAM returns at FF46.
      if (is_dma_reg) begin
         cpu_rdata = src;
      end else if (is_high) begin
         cpu_rdata = hi_rdata;
      end else if (xfer) begin
         cpu_rdata = 8'hFF;
      end else begin
         cpu_rdata = mem_rdata;
      end
   end

endmodule

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: a write to FF46 copies XFER_LEN bytes from page src into OAM.
// Optional macro GB_DMA_ECHO_MIRROR_EN folds source pages E0-FF onto C0-DF.
module gb_oam_dma
   import gb_cpu_common_pkg::*;
#(
   parameter int XFER_LEN = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_wdata_i,
   input  logic        cpu_wren_i,
   output logic [7:0]  cpu_rdata_o,
   output logic [15:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   output logic        mem_wren_o,
   input  logic [7:0]  mem_rdata_i,
   output logic [7:0]  hi_addr_o,
   output logic [7:0]  hi_wdata_o,
   output logic        hi_wren_o,
   input  logic [7:0]  hi_rdata_i,
   output logic [7:0]  oam_addr_o,
   output logic [7:0]  oam_wdata_o,
   output logic        oam_wren_o,
   output logic        dma_active_o
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t state;
   logic [7:0] src;
   logic [7:0] idx;
   logic [7:0] page;
   logic       dma_reg_wr;

   assign dma_reg_wr = cpu_wren_i & (cpu_addr_i == DMA_REG_ADDR);

`ifdef GB_DMA_ECHO_MIRROR_EN
   assign page = echo_fold(src);
`else
   assign page = src;
`endif

   // A register write restarts from any state; the current XFER byte still completes this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= DMA_IDLE;
         src   <= 8'hFF;
         idx   <= 8'h00;
      end else if (dma_reg_wr) begin
         state <= DMA_START;
         src   <= cpu_wdata_i;
         idx   <= 8'h00;
      end else begin
         case (state)
            DMA_START: begin
               state <= DMA_XFER;
            end
            DMA_XFER: begin
               if (idx == LAST_IDX) begin
                  state <= DMA_IDLE;
                  idx   <= 8'h00;
               end else begin
                  idx <= idx + 8'd1;
               end
            end
            default: begin
               state <= DMA_IDLE;
            end
         endcase
      end
   end

   assign dma_active_o = (state != DMA_IDLE);

   gb_dma_bus_mux u_bus_mux (
      .xfer      (state == DMA_XFER),
      .page      (page),
      .idx       (idx),
      .src       (src),
      .cpu_addr  (cpu_addr_i),
      .cpu_wdata (cpu_wdata_i),
      .cpu_wren  (cpu_wren_i),
      .cpu_rdata (cpu_rdata_o),
      .mem_addr  (mem_addr_o),
      .mem_wdata (mem_wdata_o),
      .mem_wren  (mem_wren_o),
      .mem_rdata (mem_rdata_i),
      .hi_addr   (hi_addr_o),
      .hi_wdata  (hi_wdata_o),
      .hi_wren   (hi_wren_o),
      .hi_rdata  (hi_rdata_i),
      .oam_addr  (oam_addr_o),
      .oam_wdata (oam_wdata_o),
      .oam_wren  (oam_wren_o)
   );

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: stimulus queues expected OAM writes, a negedge monitor compares them.
// Also covers CPU blocking, HRAM access, restart, reset abort and source page mapping.
module tb_gb_oam_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_wdata_i;
   logic        cpu_wren_i;
   logic [7:0]  cpu_rdata_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic        mem_wren_o;
   logic [7:0]  mem_rdata_i;
   logic [7:0]  hi_addr_o;
   logic [7:0]  hi_wdata_o;
   logic        hi_wren_o;
   logic [7:0]  hi_rdata_i;
   logic [7:0]  oam_addr_o;
   logic [7:0]  oam_wdata_o;
   logic        oam_wren_o;
   logic        dma_active_o;

   gb_oam_dma #(.XFER_LEN(160)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_wren_i   (cpu_wren_i),
      .cpu_rdata_o  (cpu_rdata_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_wren_o   (mem_wren_o),
      .mem_rdata_i  (mem_rdata_i),
      .hi_addr_o    (hi_addr_o),
      .hi_wdata_o   (hi_wdata_o),
      .hi_wren_o    (hi_wren_o),
      .hi_rdata_i   (hi_rdata_i),
      .oam_addr_o   (oam_addr_o),
      .oam_wdata_o  (oam_wdata_o),
      .oam_wren_o   (oam_wren_o),
      .dma_active_o (dma_active_o)
   );

   always #5 clk = ~clk;

   logic [7:0] mem  [0:65535];
   logic [7:0] hram [0:255];

   assign mem_rdata_i = mem[mem_addr_o];
   assign hi_rdata_i  = hram[hi_addr_o];

   always @(posedge clk) begin
      if (mem_wren_o) mem[mem_addr_o] <= mem_wdata_o;
      if (hi_wren_o) hram[hi_addr_o] <= hi_wdata_o;
   end

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [7:0]  oaddr;
      logic [7:0]  odata;
      logic [15:0] maddr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] oaddr, input logic [7:0] odata, input logic [15:0] maddr);
      exp_t e;
      e.oaddr = oaddr;
      e.odata = odata;
      e.maddr = maddr;
      exp_q.push_back(e);
   endtask

   // Monitor: every OAM write strobe must match the head of the scoreboard queue.
   always @(negedge clk) begin
      if (!reset && oam_wren_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL oam_unexpected: actual write idx %0h, required no write", oam_addr_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("oam_addr", 32'(oam_addr_o), 32'(mon_e.oaddr));
            check("oam_data", 32'(oam_wdata_o), 32'(mon_e.odata));
            check("dma_mem_addr", 32'(mem_addr_o), 32'(mon_e.maddr));
            check("dma_mem_wren", 32'(mem_wren_o), 32'h0);
         end
      end
   end

   task automatic cpu(input logic [15:0] a, input logic [7:0] d, input logic w);
      cpu_addr_i  = a;
      cpu_wdata_i = d;
      cpu_wren_i  = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu(a, d, 1'b1);
      tick();
      cpu(16'h0000, 8'h00, 1'b0);
   endtask

   task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] req);
      cpu(a, 8'h00, 1'b0);
      @(negedge clk);
      check(name, 32'(cpu_rdata_o), 32'(req));
      tick();
      cpu(16'h0000, 8'h00, 1'b0);
   endtask

   task automatic wait_oam_idx(input logic [7:0] k);
      bit found = 0;
      for (int n = 0; n < 400 && !found; n++) begin
         tick();
         if (oam_wren_o && oam_addr_o == k) found = 1;
      end
      if (!found) begin
         checks++;
         fails++;
         $display("FAIL wait_idx: actual timeout, required idx %0h", k);
      end
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int n = 0; n < 400 && !idle; n++) begin
         tick();
         if (!dma_active_o) idle = 1;
      end
      if (!idle) begin
         checks++;
         fails++;
         $display("FAIL wait_idle: actual still active, required idle");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_active"}, 32'(dma_active_o), 32'h0);
      check({tag, "_oam_wren"}, 32'(oam_wren_o), 32'h0);
      check({tag, "_mem_wren"}, 32'(mem_wren_o), 32'h0);
      check({tag, "_hi_wren"}, 32'(hi_wren_o), 32'h0);
      check({tag, "_oam_addr"}, 32'(oam_addr_o), 32'h0);
      check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'h0);
      check({tag, "_hi_addr"}, 32'(hi_addr_o), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [15:0] fe_base;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) hram[i] = 8'h00;
      for (int i = 0; i < 160; i++) begin
         mem[16'(16'hC100 + i)] = 8'(i ^ 8'h5A);
         mem[16'(16'hD000 + i)] = 8'(i * 3 + 7);
         mem[16'(16'hFE00 + i)] = 8'(i ^ 8'hA5);
         mem[16'(16'hDE00 + i)] = 8'(i + 1);
      end
      mem[16'h8000] = 8'h42;
      mem[16'hC000] = 8'h11;

      reset = 1'b1;
      cpu(16'h0000, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b0;
      tick();
      read_check("ff46_por", 16'hFF46, 8'hFF);

      // Basic transfer from page C1 and active-window length.
      for (int i = 0; i < 160; i++) push(8'(i), 8'(i ^ 8'h5A), 16'(16'hC100 + i));
      cpu_write(16'hFF46, 8'hC1);
      cnt = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!dma_active_o) break;
         cnt++;
      end
      check("active_cycles", 32'(cnt), 32'd161);
      check("q_empty_basic", 32'(exp_q.size()), 32'd0);
      tick();

      // CPU accesses while the DMA owns the low bus.
      for (int i = 0; i < 160; i++) push(8'(i), 8'(i ^ 8'h5A), 16'(16'hC100 + i));
      cpu_write(16'hFF46, 8'hC1);
      repeat (5) tick();
      read_check("blocked_read", 16'h8000, 8'hFF);
      cpu_write(16'hC000, 8'h77);
      cpu_write(16'hFF80, 8'h3C);
      read_check("hram_read", 16'hFF80, 8'h3C);
      read_check("ff46_xfer", 16'hFF46, 8'hC1);
      check("still_xfer", 32'(dma_active_o), 32'h1);
      wait_idle();
      check("c000_kept", 32'(mem[16'hC000]), 32'h11);
      read_check("ff46_idle", 16'hFF46, 8'hC1);
      read_check("pass_read", 16'h8000, 8'h42);
      cpu_write(16'hC000, 8'h77);
      check("pass_write", 32'(mem[16'hC000]), 32'h77);
      check("q_empty_cpu", 32'(exp_q.size()), 32'd0);

      // Restart at idx 50 with page D0.
      for (int i = 0; i <= 50; i++) push(8'(i), 8'(i ^ 8'h5A), 16'(16'hC100 + i));
      cpu_write(16'hFF46, 8'hC1);
      wait_oam_idx(8'd50);
      for (int i = 0; i < 160; i++) push(8'(i), 8'(i * 3 + 7), 16'(16'hD000 + i));
      cpu(16'hFF46, 8'hD0, 1'b1);
      tick();
      cpu(16'h0000, 8'h00, 1'b0);
      check("restart_start_wren", 32'(oam_wren_o), 32'h0);
      check("restart_start_active", 32'(dma_active_o), 32'h1);
      check("restart_start_idx", 32'(oam_addr_o), 32'h0);
      wait_idle();
      check("q_empty_restart", 32'(exp_q.size()), 32'd0);

      // Reset at idx 80 aborts immediately.
      for (int i = 0; i < 80; i++) push(8'(i), 8'(i ^ 8'h5A), 16'(16'hC100 + i));
      cpu_write(16'hFF46, 8'hC1);
      wait_oam_idx(8'd80);
      reset = 1'b1;
      #1;
      check("abort_oam_wren", 32'(oam_wren_o), 32'h0);
      check("abort_active", 32'(dma_active_o), 32'h0);
      check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      read_check("ff46_after_reset", 16'hFF46, 8'hFF);
      repeat (200) tick();
      check("q_empty_abort", 32'(exp_q.size()), 32'd0);

      // Source page FE: folded onto DE only when the mirror option is built in.
`ifdef GB_DMA_ECHO_MIRROR_EN
      fe_base = 16'hDE00;
`else
      fe_base = 16'hFE00;
`endif
      for (int i = 0; i < 160; i++) push(8'(i), mem[16'(fe_base + i)], 16'(fe_base + i));
      cpu_write(16'hFF46, 8'hFE);
      wait_idle();
      check("q_empty_fe", 32'(exp_q.size()), 32'd0);
      read_check("ff46_fe", 16'hFF46, 8'hFE);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/gb_oam_dma.md
GB_OAM_DMA -- requirements
Module: gb_oam_dma

Interface
REQ-001 Param XFER_LEN, default 160, number of bytes per OAM DMA transfer.
REQ-002 clk  input  1  machine (M) clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr_i  input  16  CPU address bus.
REQ-005 cpu_wdata_i  input  8  CPU outgoing data.
REQ-006 cpu_wren_i  input  1  CPU drive_data_bus (write strobe).
REQ-007 cpu_rdata_o  output  8  read data returned to CPU.
REQ-008 mem_addr_o  output  16  low-bus address (0000-FEFF space).
REQ-009 mem_wdata_o  output  8  low-bus write data.
REQ-010 mem_wren_o  output  1  low-bus write enable.
REQ-011 mem_rdata_i  input  8  low-bus read data, valid in the same cycle as mem_addr_o.
REQ-012 hi_addr_o  output  8  high-page (FF00-FFFF) offset; hi_wdata_o output 8, hi_wren_o output 1, hi_rdata_i input 8.
REQ-013 oam_addr_o  output  8  OAM write index; oam_wdata_o output 8; oam_wren_o output 1.
REQ-014 dma_active_o  output  1  high whenever state != IDLE.

Function
REQ-015 States IDLE, START, XFER; state, src page register and 8-bit index idx are registered.
REQ-016 CPU write to FF46 (cpu_wren_i=1, cpu_addr_i=FF46) in any state: at that edge src <= cpu_wdata_i, idx <= 0, state <= START.
REQ-017 START lasts exactly one cycle, then state <= XFER.
REQ-018 XFER: mem_addr_o = {page, idx}, mem_wren_o=0, oam_addr_o=idx, oam_wdata_o=mem_rdata_i, oam_wren_o=1; idx increments each edge.
REQ-019 XFER with idx = XFER_LEN-1: at that edge state <= IDLE, idx <= 0.
REQ-020 Latency: write at cycle W -> START in W+1, XFER in W+2..W+161, IDLE from W+162; dma_active_o high W+1..W+161.
REQ-021 Restart during XFER: the write cycle still performs its transfer at the old idx; the next cycle is START with the new src.
REQ-022 Outside XFER, oam_wren_o=0 and low-bus accesses (cpu_addr_i < FF00) pass through: mem_addr_o=cpu_addr_i, mem_wdata_o=cpu_wdata_i, mem_wren_o=cpu_wren_i, cpu_rdata_o=mem_rdata_i.
REQ-023 During XFER, CPU low-bus accesses are blocked: writes dropped, cpu_rdata_o=8'hFF.
REQ-024 High-page accesses (cpu_addr_i >= FF00) are always routed to hi_* in every state; hi_wren_o=cpu_wren_i, cpu_rdata_o=hi_rdata_i.
REQ-025 CPU read of FF46 returns src, overriding hi_rdata_i; the FF46 write also propagates to hi_wren_o.
REQ-026 DMA never writes the high page; it has priority over the CPU on the low bus only during XFER.

Reset
REQ-027 Asynchronous reset: state=IDLE, idx=0, src=8'hFF; reset during START or XFER aborts the transfer immediately.
REQ-028 Reset values: dma_active_o=0, oam_wren_o=0, mem_wren_o=0, hi_wren_o=0, oam_addr_o=0, mem_addr_o=0 and hi_addr_o=0 when the CPU inputs are zero.

Configuration
REQ-029 Macro GB_DMA_ECHO_MIRROR_EN defined: src pages E0-FF source from page - 8'h20 (C0-DF).
REQ-030 Macro undefined: page = src unmodified for all values.

Structure
REQ-031 dma_state_t, DMA_REG_ADDR (16'hFF46) and HIGH_PAGE_BASE (16'hFF00) belong in gb_cpu_common_pkg.
REQ-032 The purely combinational bus routing (REQ-022..026) is placed in sub-module gb_dma_bus_mux; the FSM and counters stay in gb_oam_dma.

Verification
REQ-033 Write FF46=C1, memory C100+i=i^5A -> OAM i=i^5A for i=0..159, dma_active_o high exactly 161 cycles.
REQ-034 CPU read 8000 during XFER -> cpu_rdata_o=FF; CPU write C000=77 during XFER -> C000 unchanged; HRAM FF80 write/read=3C succeeds.
REQ-035 Rewrite FF46=D0 at idx 50 -> idx 50 transferred from C1, one START cycle, then OAM 0..159 from D000.
REQ-036 Assert reset at idx 80 -> oam_wren_o and dma_active_o fall immediately; OAM 80..159 not written; FF46 read=FF.
REQ-037 FF46=FE with GB_DMA_ECHO_MIRROR_EN -> mem_addr_o DE00..DE9F; without it -> FE00..FE9F.
REQ-038 Read FF46 after writing C1 -> cpu_rdata_o=C1 in IDLE and during XFER.
